// File: rtl/mor1kx_rf_banked.sv
// Banked GPR file: N registered read ports with write bypass/hold coherence, SPR access, clear FSM.
// Optional feature: define MOR1KX_RF_PARITY_EN for per-entry even parity and parity_err_o.
module mor1kx_rf_banked #(
    parameter int unsigned OPTION_OPERAND_WIDTH     = 32,
    parameter int unsigned OPTION_RF_ADDR_WIDTH     = 5,
    parameter int unsigned OPTION_RF_NUM_BANKS      = 1,
    parameter int unsigned OPTION_RF_READ_PORTS     = 2,
    parameter int unsigned OPTION_RF_CLEAR_ON_RESET = 1,
    parameter int unsigned OPTION_RF_R0_ZERO        = 1,
    localparam int unsigned DW = OPTION_OPERAND_WIDTH,
    localparam int unsigned AW = OPTION_RF_ADDR_WIDTH,
    localparam int unsigned NR = OPTION_RF_READ_PORTS,
    localparam int unsigned BW = (OPTION_RF_NUM_BANKS > 1) ? $clog2(OPTION_RF_NUM_BANKS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BW-1:0]    bank_sel_i,
    input  logic [NR-1:0]    rd_en_i,
    input  logic [NR*AW-1:0] rd_adr_i,
    output logic [NR*DW-1:0] rd_dat_o,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_adr_i,
    input  logic [DW-1:0]    wr_dat_i,
    input  logic             spr_stb_i,
    input  logic             spr_we_i,
    input  logic [BW+AW-1:0] spr_adr_i,
    input  logic [DW-1:0]    spr_dat_i,
    output logic             spr_ack_o,
    output logic [DW-1:0]    spr_dat_o,
    input  logic             clear_i,
    output logic             busy_o
`ifdef MOR1KX_RF_PARITY_EN
    ,
    output logic [NR-1:0]    parity_err_o
`endif
);

    localparam int unsigned LBW     = $clog2(OPTION_RF_NUM_BANKS);
    localparam int unsigned EW      = AW + LBW;
    localparam int unsigned ENTRIES = OPTION_RF_NUM_BANKS << AW;
`ifdef MOR1KX_RF_PARITY_EN
    localparam int unsigned MW = DW + 1;
`else
    localparam int unsigned MW = DW;
`endif
    localparam logic [EW-1:0] LAST    = EW'(ENTRIES - 1);
    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_CLEAR = 1'b1;

    // Flat entry index {bank, adr}; bank bits vanish when there is a single bank.
    function automatic logic [EW-1:0] flat_idx(input logic [BW-1:0] bank, input logic [AW-1:0] adr);
        return (EW'(bank) << AW) | EW'(adr);
    endfunction

    function automatic logic [MW-1:0] mk_word(input logic [DW-1:0] d);
`ifdef MOR1KX_RF_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    logic [MW-1:0] r_mem [ENTRIES];
    logic [0:0]    r_state, w_state_nx;
    logic [EW-1:0] r_cnt, w_cnt_nx, w_clr_idx;
    logic          w_busy;
    logic          w_we, w_spr_wr, w_spr_rd;
    logic [EW-1:0] w_widx, w_spr_idx;
    logic [MW-1:0] w_wdat, w_spr_word;
    logic          r_spr_ack;
    logic [DW-1:0] r_spr_dat;

    assign w_busy    = (r_state == S_CLEAR);
    assign busy_o    = w_busy;
    assign spr_ack_o = r_spr_ack;
    assign spr_dat_o = r_spr_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= (OPTION_RF_CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // A clear request restarts the sweep so the current cycle already writes entry 0.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_clr_idx  = clear_i ? '0 : r_cnt;
        case (r_state)
            S_IDLE: begin
                if (clear_i) begin
                    w_state_nx = S_CLEAR;
                    w_cnt_nx   = '0;
                end
            end
            S_CLEAR: begin
                if (w_clr_idx == LAST) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = w_clr_idx + EW'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_spr_idx = flat_idx(spr_adr_i[BW+AW-1:AW], spr_adr_i[AW-1:0]);

    // Single write port: clear > pipeline > SPR.
    always_comb begin
        w_we     = 1'b0;
        w_spr_wr = 1'b0;
        w_widx   = w_clr_idx;
        w_wdat   = '0;
        if (w_busy) begin
            w_we = 1'b1;
        end else if (wr_en_i) begin
            w_we   = 1'b1;
            w_widx = flat_idx(bank_sel_i, wr_adr_i);
            w_wdat = mk_word(wr_dat_i);
        end else if (spr_stb_i && spr_we_i && !r_spr_ack) begin
            w_we     = 1'b1;
            w_spr_wr = 1'b1;
            w_widx   = w_spr_idx;
            w_wdat   = mk_word(spr_dat_i);
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_widx] <= w_wdat;
    end

    assign w_spr_rd   = spr_stb_i && !spr_we_i && !w_busy && !r_spr_ack;
    assign w_spr_word = (w_we && (w_widx == w_spr_idx)) ? w_wdat : r_mem[w_spr_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spr_ack <= 1'b0;
            r_spr_dat <= '0;
        end else begin
            r_spr_ack <= w_spr_wr | w_spr_rd;
            if (w_spr_rd) r_spr_dat <= w_spr_word[DW-1:0];
        end
    end

    // Each port re-reads its held index every cycle so later writes stay visible.
    for (genvar p = 0; p < NR; p++) begin : g_rd
        logic [EW-1:0] r_idx, w_idx;
        logic [MW-1:0] w_word;
        logic          w_zero;
        logic [DW-1:0] r_dat;

        always_comb begin
            w_idx  = rd_en_i[p] ? flat_idx(bank_sel_i, rd_adr_i[p*AW +: AW]) : r_idx;
            w_word = (w_we && (w_widx == w_idx)) ? w_wdat : r_mem[w_idx];
            w_zero = w_busy || ((OPTION_RF_R0_ZERO != 0) && (w_idx[AW-1:0] == '0));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_idx <= '0;
                r_dat <= '0;
            end else begin
                r_idx <= w_idx;
                r_dat <= w_zero ? '0 : w_word[DW-1:0];
            end
        end

        assign rd_dat_o[p*DW +: DW] = r_dat;

`ifdef MOR1KX_RF_PARITY_EN
        logic r_perr;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_perr <= 1'b0;
            else        r_perr <= !w_zero && (^w_word);
        end
        assign parity_err_o[p] = r_perr;
`endif
    end

endmodule
